oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA engine: the bus initiator that fills sprite attribute memory. A CPU write to 0xFF46 latches a source page. The block then copies `XFER_BYTES` bytes from `{page, 8'h00}` upward into OAM at 0xFE00 upward, acting as master on a dedicated source-read port and on the OAM write port. It sits beside the PPU, which remains the OAM/VRAM responder for the MMU, and raises `busy` so the MMU can block CPU non-HRAM accesses for the duration.

## Interface
Parameters:
- `XFER_BYTES`, 160, number of bytes copied; range 1..256.
- `BYTE_CYCLES`, 4, clock cycles per byte slot; must be ≥ 3.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  reset; **synchronous, active-low**.
- `A_mmu`  in  16  CPU bus address.
- `Di_mmu`  in  8  CPU write data.
- `cs_mmu`  in  1  CPU bus select.
- `wr_mmu`  in  1  CPU write strobe.
- `dma_reg`  out  8  last value written to 0xFF46; the MMU returns it on reads.
- `A_src`  out  16  source read address.
- `rd_src`  out  1  source read strobe.
- `Di_src`  in  8  source read data, valid one cycle after `rd_src`.
- `A_oam`  out  16  OAM write address (0xFE00 + index).
- `Do_oam`  out  8  OAM write data.
- `wr_oam`  out  1  OAM write strobe, one cycle per byte.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.

## Operation
- **Trigger:** `cs_mmu && wr_mmu && A_mmu == 16'hFF46` loads `dma_reg <= Di_mmu` and starts a transfer.
- **Page mapping:** the effective page is `Di_mmu`. If the page is ≥ 0xE0, the effective page is page − 0x20 (echo RAM maps to WRAM).
- **State machine:** IDLE, XFER.
  - IDLE → XFER on a trigger; `index` = 0, `phase` = 0.
  - XFER → IDLE after the last phase of byte `XFER_BYTES`−1.
- **Per-byte phases in XFER:**
  - phase 0: `A_src = {page, index}`, `rd_src = 1`.
  - phase 1: latch `Di_src` into the data register.
  - phase 2: `A_oam = 16'hFE00 + index`, `Do_oam` = latched data, `wr_oam = 1`.
  - phases 3..`BYTE_CYCLES`−1: idle.
  - On the last phase: `phase` returns to 0 and `index` increments.
- **Strobes:** `rd_src` and `wr_oam` are each high for exactly one cycle per byte, never in the same cycle.
- **Restart:** a trigger during XFER restarts immediately.
  - Loads the new page; `index` = 0, `phase` = 0.
  - Any byte in flight is abandoned; its OAM write does not happen if it has not yet occurred.
  - No `done` pulse for the aborted transfer.
- **Index width:** `index` is 8 bits; `A_src` low byte = `index`, so there is no carry into the page.
- **Reset values:** all outputs 0, including `dma_reg`, `A_src`, `A_oam`, `Do_oam`, `rd_src`, `wr_oam`, `busy`, `done`; state IDLE.
- **Reset mid-transfer:** the transfer aborts at the next edge, with no further writes and no `done`.

## Timing
- Trigger sampled at edge N: `busy` = 1 and first `rd_src` = 1 in cycle N+1.
- Byte k:
  - read in cycle N+1+k·`BYTE_CYCLES`.
  - OAM write two cycles later.
- `busy` is high for exactly `XFER_BYTES`·`BYTE_CYCLES` cycles (640 at defaults).
  - `done` pulses in the first cycle `busy` is low.
- Trigger in the same cycle as the final phase: the restart wins; `busy` stays high and `done` does not pulse.
- Writes to other addresses have no effect, regardless of `busy`.

## Structure
- Shared package holds:
  - `DMA_REG_ADDR` = 16'hFF46
  - `OAM_BASE` = 16'hFE00
  - `ECHO_PAGE_MIN` = 8'hE0
  - `ECHO_OFFSET` = 8'h20
  - state enum {IDLE, XFER}
- Single module; no sub-module. The phase/index counter is inline.

## Test plan
- Write 0xC1 to 0xFF46 with source = `index` ^ 0x5A → `dma_reg` = 0xC1; `busy` rises next cycle.
  - 160 OAM writes: FE00..FE9F with data = i ^ 0x5A.
  - `busy` high for 640 cycles; one `done` pulse.
- Write 0xE3 → `A_src` runs C300..C39F.
- At byte 50, write 0xD0 → OAM restarts at FE00 with the D0xx source; no `done` until 640 cycles after the second write.
- Assert `reset_n` = 0 at byte 80 → next cycle `busy` = 0, `wr_oam` = 0, `dma_reg` = 0; no further writes and no `done`.
- Writes to 0xFF45 and 0xFF47 → no transfer; `dma_reg` unchanged.
- Check strobe spacing: `wr_oam` exactly 2 cycles after each `rd_src`; consecutive `rd_src` exactly 4 cycles apart.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared constants, state encoding and page mapping for the OAM DMA engine
//
// Purpose: constants and helpers shared by the OAM DMA engine.
//   DMA_REG_ADDR  : CPU address of the DMA source-page register
//   OAM_BASE      : first OAM address written by a transfer
//   ECHO_PAGE_MIN : first page of the echo RAM window
//   ECHO_OFFSET   : distance from echo RAM back to work RAM, in pages
//   state_t       : engine state (IDLE, XFER)
//   map_page()    : folds echo RAM pages onto the work RAM they mirror

package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam logic [7:0]  ECHO_PAGE_MIN = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET   = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Pages 0xE0..0xFF are echo RAM; the copy reads the work RAM behind them.
  function automatic logic [7:0] map_page(input logic [7:0] page);
    return (page >= ECHO_PAGE_MIN) ? (page - ECHO_OFFSET) : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA engine copying one source page into sprite attribute memory
//
// Purpose: a CPU write to the DMA register latches a source page and starts
// a copy of XFER_BYTES bytes from {page, 8'h00} upward into OAM at 0xFE00
// upward. Each byte occupies BYTE_CYCLES clock cycles: read strobe, data
// capture, OAM write strobe, then idle slots.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   A_mmu    in   CPU bus address
//   Di_mmu   in   CPU write data
//   cs_mmu   in   CPU bus select
//   wr_mmu   in   CPU write strobe
//   dma_reg  out  last value written to the DMA register
//   A_src    out  source read address
//   rd_src   out  source read strobe
//   Di_src   in   source read data, valid the cycle after rd_src
//   A_oam    out  OAM write address
//   Do_oam   out  OAM write data
//   wr_oam   out  OAM write strobe
//   busy     out  transfer in progress
//   done     out  one-cycle pulse after the last byte of a transfer

module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int XFER_BYTES  = 160,
  parameter int BYTE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] A_mmu,
  input  logic [7:0]  Di_mmu,
  input  logic        cs_mmu,
  input  logic        wr_mmu,
  output logic [7:0]  dma_reg,
  output logic [15:0] A_src,
  output logic        rd_src,
  input  logic [7:0]  Di_src,
  output logic [15:0] A_oam,
  output logic [7:0]  Do_oam,
  output logic        wr_oam,
  output logic        busy,
  output logic        done
);

  localparam int PHASE_W = $clog2(BYTE_CYCLES);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BYTE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] CAPTURE_PHASE = PHASE_W'(1);
  localparam logic [7:0] LAST_INDEX = 8'(XFER_BYTES - 1);

  state_t             state;
  logic [7:0]         page;
  logic [7:0]         index;
  logic [PHASE_W-1:0] phase;
  logic               trigger;
  logic [7:0]         trig_page;

  assign trigger   = cs_mmu && wr_mmu && (A_mmu == DMA_REG_ADDR);
  assign trig_page = map_page(Di_mmu);

  // phase/index name the slot being presented on the outputs in the current
  // cycle; every edge computes the registered strobes for the following slot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      page    <= 8'h00;
      index   <= 8'h00;
      phase   <= '0;
      dma_reg <= 8'h00;
      A_src   <= 16'h0000;
      rd_src  <= 1'b0;
      A_oam   <= 16'h0000;
      Do_oam  <= 8'h00;
      wr_oam  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_src <= 1'b0;
      wr_oam <= 1'b0;
      done   <= 1'b0;

      if (trigger) begin
        // A new trigger always wins, even over the last slot of a running
        // transfer: the old byte in flight is dropped and no done is raised.
        dma_reg <= Di_mmu;
        page    <= trig_page;
        state   <= XFER;
        index   <= 8'h00;
        phase   <= '0;
        busy    <= 1'b1;
        rd_src  <= 1'b1;
        A_src   <= {trig_page, 8'h00};
      end else if (state == XFER) begin
        if (phase == LAST_PHASE) begin
          if (index == LAST_INDEX) begin
            state <= IDLE;
            index <= 8'h00;
            phase <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            // Index stays 8 bits so the source address never carries into
            // the page byte.
            index  <= index + 8'd1;
            phase  <= '0;
            rd_src <= 1'b1;
            A_src  <= {page, index + 8'd1};
          end
        end else begin
          phase <= phase + PHASE_W'(1);
          if (phase == CAPTURE_PHASE) begin
            // Source data arrives in the slot after the read; it lands
            // straight in the OAM data register for the write slot.
            Do_oam <= Di_src;
            A_oam  <= OAM_BASE + {8'h00, index};
            wr_oam <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for the OAM DMA engine

module tb_oam_dma;

  localparam int XB    = 160;
  localparam int BC    = 4;
  localparam int TOTAL = XB * BC;

  logic        clock;
  logic        reset_n;
  logic [15:0] A_mmu;
  logic [7:0]  Di_mmu;
  logic        cs_mmu;
  logic        wr_mmu;
  logic [7:0]  dma_reg;
  logic [15:0] A_src;
  logic        rd_src;
  logic [7:0]  Di_src;
  logic [15:0] A_oam;
  logic [7:0]  Do_oam;
  logic        wr_oam;
  logic        busy;
  logic        done;

  oam_dma #(.XFER_BYTES(XB), .BYTE_CYCLES(BC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .A_mmu   (A_mmu),
    .Di_mmu  (Di_mmu),
    .cs_mmu  (cs_mmu),
    .wr_mmu  (wr_mmu),
    .dma_reg (dma_reg),
    .A_src   (A_src),
    .rd_src  (rd_src),
    .Di_src  (Di_src),
    .A_oam   (A_oam),
    .Do_oam  (Do_oam),
    .wr_oam  (wr_oam),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Source memory contents: page C1 holds i ^ 0x5A; other pages are offset
  // so that a wrong page shows up in the data as well as the address.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = a[7:0];
    hi = a[15:8];
    return lo ^ 8'h5A ^ (hi - 8'hC1);
  endfunction

  // Source port responder: data valid only in the cycle after rd_src.
  always @(posedge clock) begin
    logic        r;
    logic [15:0] a;
    r = rd_src;
    a = A_src;
    #1;
    Di_src = r ? src_byte(a) : 8'($urandom);
  end

  // Reference model: remembers only the most recent trigger (edge count and
  // page) and derives every expected output from the elapsed time.
  int         cyc = 0;
  int         m_t0 = 0;
  bit         m_active = 0;
  bit         m_fresh = 1;
  logic [7:0] m_page = 8'h00;
  logic [7:0] m_dma = 8'h00;

  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      m_active = 0;
      m_fresh  = 1;
      m_dma    = 8'h00;
    end else if (cs_mmu && wr_mmu && A_mmu == 16'hFF46) begin
      m_dma    = Di_mmu;
      m_page   = (Di_mmu >= 8'hE0) ? Di_mmu - 8'h20 : Di_mmu;
      m_t0     = cyc;
      m_active = 1;
      m_fresh  = 0;
    end
  end

  bit          chk_en = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          last_rd_cyc = -100;
  logic [15:0] last_rd_addr = 16'h0000;

  always @(negedge clock) begin
    if (chk_en) begin
      int          off;
      int          k;
      int          ph;
      bit          e_busy, e_done, e_rd, e_wr, ok;
      logic [15:0] e_asrc, e_aoam;
      logic [7:0]  e_do;
      e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0;
      e_asrc = 16'h0; e_aoam = 16'h0; e_do = 8'h0;
      if (m_active) begin
        off = cyc - m_t0;
        if (off < TOTAL) begin
          e_busy = 1;
          k  = off / BC;
          ph = off % BC;
          if (ph == 0) begin
            e_rd   = 1;
            e_asrc = {m_page, 8'(k)};
          end
          if (ph == 2) begin
            e_wr   = 1;
            e_aoam = 16'hFE00 + 16'(k);
            e_do   = src_byte({m_page, 8'(k)});
          end
        end else if (off == TOTAL) begin
          e_done = 1;
        end
      end
      ok = (busy == e_busy) && (done == e_done) && (rd_src == e_rd) && (wr_oam == e_wr)
        && (dma_reg == m_dma)
        && (!e_rd || A_src == e_asrc)
        && (!e_wr || (A_oam == e_aoam && Do_oam == e_do))
        && (!m_fresh || (A_src == 16'h0 && A_oam == 16'h0 && Do_oam == 8'h0));
      check(ok, "cycle_model",
            {12'h0, busy, done, rd_src, wr_oam, dma_reg, A_src, A_oam, Do_oam},
            {12'h0, e_busy, e_done, e_rd, e_wr, m_dma, e_asrc, e_aoam, e_do});

      if (wr_oam) check(cyc - last_rd_cyc == 2, "rd_to_wr_spacing", 64'(cyc - last_rd_cyc), 64'd2);
      if (rd_src && last_rd_cyc >= m_t0 && !m_fresh)
        check(cyc - last_rd_cyc == BC, "rd_spacing", 64'(cyc - last_rd_cyc), 64'(BC));

      if (wr_oam) wr_cnt++;
      if (done)   done_cnt++;
      if (busy)   busy_cnt++;
      if (rd_src) begin
        last_rd_cyc  = cyc;
        last_rd_addr = A_src;
      end
    end
  end

  // All stimulus tasks are entered at a negedge and return at a negedge.
  task automatic bus_op(input logic [15:0] a, input logic [7:0] d, input logic cs, input logic wr);
    A_mmu  = a;
    Di_mmu = d;
    cs_mmu = cs;
    wr_mmu = wr;
    @(negedge clock);
    cs_mmu = 1'b0;
    wr_mmu = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        cs;
    logic        wr;
    logic [7:0]  exp_dma;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int s_wr, s_done, s_busy;

    vecs[0] = '{16'hFF45, 8'h77, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{16'hFF47, 8'h77, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{16'hFF46, 8'h33, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{16'hFF46, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{16'hFF46, 8'hC1, 1'b1, 1'b1, 8'hC1, 1'b1};

    reset_n = 1'b0;
    A_mmu = 16'h0; Di_mmu = 8'h0; cs_mmu = 1'b0; wr_mmu = 1'b0;
    wait_cycles(3);
    chk_en = 1;
    reset_n = 1'b1;
    wait_cycles(1);
    check({dma_reg, A_src, A_oam, Do_oam, rd_src, wr_oam, busy, done} == '0, "reset_state",
          {dma_reg, A_src, A_oam, Do_oam, rd_src, wr_oam, busy, done}, 64'h0);

    // Table: non-triggering accesses leave the register alone, then a real trigger.
    s_wr = wr_cnt; s_done = done_cnt; s_busy = busy_cnt;
    for (int i = 0; i < 5; i++) begin
      bus_op(vecs[i].addr, vecs[i].data, vecs[i].cs, vecs[i].wr);
      check(dma_reg == vecs[i].exp_dma, $sformatf("vec%0d_dma_reg", i), 64'(dma_reg), 64'(vecs[i].exp_dma));
      check(busy == vecs[i].exp_busy, $sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
    end
    check(rd_src == 1'b1 && A_src == 16'hC100, "first_read", {47'h0, rd_src, A_src}, {47'h0, 1'b1, 16'hC100});
    wait_cycles(700);
    check(wr_cnt - s_wr == XB, "oam_write_count", 64'(wr_cnt - s_wr), 64'(XB));
    check(done_cnt - s_done == 1, "done_count", 64'(done_cnt - s_done), 64'd1);
    check(busy_cnt - s_busy == TOTAL, "busy_cycles", 64'(busy_cnt - s_busy), 64'(TOTAL));

    // Writes to neighbouring registers while idle.
    bus_op(16'hFF45, 8'h12, 1'b1, 1'b1);
    bus_op(16'hFF47, 8'h34, 1'b1, 1'b1);
    check(dma_reg == 8'hC1 && busy == 1'b0, "neighbour_writes", {dma_reg, busy}, {8'hC1, 1'b0});

    // Echo page maps back into work RAM.
    bus_op(16'hFF46, 8'hE3, 1'b1, 1'b1);
    check(A_src == 16'hC300 && dma_reg == 8'hE3, "echo_first_addr", {dma_reg, A_src}, {8'hE3, 16'hC300});
    wait_cycles(700);
    check(last_rd_addr == 16'hC39F, "echo_last_addr", 64'(last_rd_addr), 64'hC39F);

    // Restart at byte 50; done only 640 cycles after the second write.
    bus_op(16'hFF46, 8'hC1, 1'b1, 1'b1);
    wait_cycles(200 - 1);
    s_done = done_cnt;
    bus_op(16'hFF46, 8'hD0, 1'b1, 1'b1);
    check(A_src == 16'hD000 && rd_src == 1'b1, "restart_addr", {rd_src, A_src}, {1'b1, 16'hD000});
    wait_cycles(TOTAL - 1);
    check(busy == 1'b1 && done == 1'b0, "restart_last_busy", {busy, done}, {1'b1, 1'b0});
    wait_cycles(1);
    check(busy == 1'b0 && done == 1'b1, "restart_done", {busy, done}, {1'b0, 1'b1});
    wait_cycles(2);
    check(done_cnt - s_done == 1, "restart_single_done", 64'(done_cnt - s_done), 64'd1);

    // Trigger landing on the final slot: restart wins, no done.
    bus_op(16'hFF46, 8'hC2, 1'b1, 1'b1);
    wait_cycles(TOTAL - 1);
    bus_op(16'hFF46, 8'hC4, 1'b1, 1'b1);
    check(busy == 1'b1 && done == 1'b0 && A_src == 16'hC400, "final_slot_restart",
          {busy, done, A_src}, {1'b1, 1'b0, 16'hC400});
    wait_cycles(700);

    // Reset at byte 80.
    bus_op(16'hFF46, 8'hC1, 1'b1, 1'b1);
    wait_cycles(80 * BC);
    s_wr = wr_cnt; s_done = done_cnt;
    reset_pulse();
    check(busy == 1'b0 && wr_oam == 1'b0 && dma_reg == 8'h00, "reset_mid_xfer",
          {busy, wr_oam, dma_reg}, {1'b0, 1'b0, 8'h00});
    wait_cycles(700);
    check(wr_cnt - s_wr == 0 && done_cnt - s_done == 0, "after_reset_quiet",
          {32'(wr_cnt - s_wr), 32'(done_cnt - s_done)}, 64'h0);

    // Random mix of triggers, stray writes and resets against the model.
    for (int it = 0; it < 25; it++) begin
      int          r;
      logic [15:0] a;
      r = $urandom_range(0, 99);
      if (r < 65) begin
        bus_op(16'hFF46, 8'($urandom), 1'b1, 1'b1);
      end else if (r < 80) begin
        a = 16'hFF40 + 16'($urandom_range(0, 15));
        if (a == 16'hFF46) a = 16'hFF47;
        bus_op(a, 8'($urandom), 1'b1, 1'b1);
      end else if (r < 90) begin
        reset_pulse();
      end else begin
        bus_op(16'hFF46, 8'($urandom), 1'b0, 1'b1);
      end
      wait_cycles($urandom_range(0, 800));
    end
    wait_cycles(700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
